// File: rtl/serial_pair_transmitter_using_fsm.sv
// Two-line bit-serial transmitter: accepts an (A, B) word pair on a valid/ready handshake and
// shifts both words out in lock-step with first/last framing strobes.
module serial_pair_transmitter_using_fsm #(
    parameter int unsigned W         = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_a,
    input  logic [W-1:0] up_b,
    output logic         a,
    output logic         b,
    output logic         bit_valid,
    output logic         first,
    output logic         last
);
    localparam int unsigned   CW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CntLast = CW'(W - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic          at_last;
    logic          xfer;

    assign at_last  = (state_q == StShift) && (cnt_q == CntLast);
    // Ready is a function of registered state only, so it never depends on up_valid.
    assign up_ready = !rst && ((state_q == StIdle) || at_last);
    assign xfer     = up_valid && up_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    sh_a_d  = up_a;
                    sh_b_d  = up_b;
                end
            end
            StShift: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (xfer) begin
                        // Back-to-back reload: no idle bubble between words.
                        sh_a_d = up_a;
                        sh_b_d = up_b;
                    end else begin
                        state_d = StIdle;
                        sh_a_d  = '0;
                        sh_b_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (MSB_FIRST) begin
                        sh_a_d = sh_a_q << 1;
                        sh_b_d = sh_b_q << 1;
                    end else begin
                        sh_a_d = sh_a_q >> 1;
                        sh_b_d = sh_b_q >> 1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
        end
    end

    // The current bit always sits at the outgoing end of the shift register.
    assign bit_valid = (state_q == StShift);
    assign a         = bit_valid && (MSB_FIRST ? sh_a_q[W-1] : sh_a_q[0]);
    assign b         = bit_valid && (MSB_FIRST ? sh_b_q[W-1] : sh_b_q[0]);
    assign first     = bit_valid && (cnt_q == '0);
    assign last      = at_last;

endmodule

// File: tb/tb_serial_pair_transmitter_using_fsm.sv
// Bench for serial_pair_transmitter_using_fsm: three instances (W=16 MSB-first, W=16 LSB-first,
// W=1) checked every cycle against a queue-of-expected-bits model.
module tb_serial_pair_transmitter_using_fsm;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        v0, v1, v2;
    logic [15:0] a0, b0, a1, b1;
    logic [0:0]  a2, b2;
    logic        r0, r1, r2;
    logic        sa0, sb0, bv0, f0, l0;
    logic        sa1, sb1, bv1, f1, l1;
    logic        sa2, sb2, bv2, f2, l2;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];
    logic  acc0, acc1, acc2;
    logic  rnd_mode;
    int    total;
    int    bad;
    int    cyc;

    serial_pair_transmitter_using_fsm #(.W(16), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .up_valid(v0), .up_ready(r0), .up_a(a0), .up_b(b0),
        .a(sa0), .b(sb0), .bit_valid(bv0), .first(f0), .last(l0)
    );

    serial_pair_transmitter_using_fsm #(.W(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .up_valid(v1), .up_ready(r1), .up_a(a1), .up_b(b1),
        .a(sa1), .b(sb1), .bit_valid(bv1), .first(f1), .last(l1)
    );

    serial_pair_transmitter_using_fsm #(.W(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .up_valid(v2), .up_ready(r2), .up_a(a2), .up_b(b2),
        .a(sa2), .b(sb2), .bit_valid(bv2), .first(f2), .last(l2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    // An accepted word becomes W beats, bit i taken from index W-1-i (MSB first) or i.
    function automatic void load(int d, logic [15:0] wa, logic [15:0] wb);
        int    w;
        bit    msb;
        int    idx;
        beat_t e;
        w   = (d == 2) ? 1 : 16;
        msb = (d != 1);
        for (int i = 0; i < w; i++) begin
            idx     = msb ? (w - 1 - i) : i;
            e.a     = wa[idx];
            e.b     = wb[idx];
            e.first = (i == 0);
            e.last  = (i == w - 1);
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    endfunction

    // Expected {a, b, bit_valid, first, last, up_ready}.
    function automatic logic [5:0] want(int d);
        int    n;
        beat_t e;
        n = qsize(d);
        e = '0;
        if (n > 0) e = (d == 0) ? q0[0] : (d == 1) ? q1[0] : q2[0];
        return {e.a, e.b, (n > 0), e.first, e.last, (!rst && n <= 1)};
    endfunction

    task automatic chk(string tag, logic [5:0] obs, logic [5:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, req);
        end
    endtask

    // One clock: check at negedge, then update the model just after the posedge.
    task automatic tick();
        @(negedge clk);
        chk("msb16", {sa0, sb0, bv0, f0, l0, r0}, want(0));
        chk("lsb16", {sa1, sb1, bv1, f1, l1, r1}, want(1));
        chk("w1",    {sa2, sb2, bv2, f2, l2, r2}, want(2));
        acc0 = v0 && !rst && (q0.size() <= 1);
        acc1 = v1 && !rst && (q1.size() <= 1);
        acc2 = v2 && !rst && (q2.size() <= 1);
        @(posedge clk);
        #1;
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
        if (q2.size() > 0) void'(q2.pop_front());
        if (acc0) load(0, a0, b0);
        if (acc1) load(1, a1, b1);
        if (acc2) load(2, {15'd0, a2}, {15'd0, b2});
        if (rnd_mode) begin
            if (acc0 || !v0) begin
                v0 = ($urandom_range(0, 3) != 0); a0 = 16'($urandom); b0 = 16'($urandom);
            end
            if (acc1 || !v1) begin
                v1 = ($urandom_range(0, 3) != 0); a1 = 16'($urandom); b1 = 16'($urandom);
            end
            if (acc2 || !v2) begin
                v2 = ($urandom_range(0, 2) != 0); a2 = 1'($urandom); b2 = 1'($urandom);
            end
        end
        cyc++;
    endtask

    // Present a pair to the MSB-first instance and hold it until taken; valid stays high.
    task automatic send0(logic [15:0] wa, logic [15:0] wb);
        int k;
        k  = 0;
        v0 = 1'b1;
        a0 = wa;
        b0 = wb;
        do begin
            tick();
            k++;
        end while (!acc0 && k < 40);
        total++;
        assert (acc0 === 1'b1) else begin
            bad++;
            $error("FAIL send0_timeout cyc=%0d observed=%b expected=1", cyc, acc0);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; rnd_mode = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0; acc2 = 1'b0;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;

        // Reset held: everything, including up_ready, must read 0.
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed words on both 16-bit instances; W=1 back-to-back pairs.
        v0 = 1'b1; a0 = 16'h4126; b0 = 16'h4646;
        v1 = 1'b1; a1 = 16'h4106; b1 = 16'h5646;
        v2 = 1'b1; a2 = 1'b1;     b2 = 1'b0;
        tick();
        v0 = 1'b0; v1 = 1'b0;
        a2 = 1'b0; b2 = 1'b1;
        tick();
        a2 = 1'b1; b2 = 1'b1;
        tick();
        v2 = 1'b0;
        repeat (17) tick();

        // Back-to-back with valid held high; second pair waits through the busy cycles.
        send0(16'hFFFF, 16'h0000);
        send0(16'h0000, 16'hFFFF);
        v0 = 1'b0;
        repeat (18) tick();

        // Asynchronous reset in the middle of bit 7.
        send0(16'hA5C3, 16'h3C5A);
        v0 = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {sa0, sb0, bv0, f0, l0, r0}, 6'b000000);
        q0.delete(); q1.delete(); q2.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        send0(16'h8001, 16'h0001);
        v0 = 1'b0;
        repeat (17) tick();

        // Randomized traffic on all three instances.
        rnd_mode = 1'b1;
        repeat (600) tick();
        rnd_mode = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
